flag_cond_unit: RTL and testbench

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

---
 rtl/flag_cond_unit.sv | 103 ++++++++++
 tb/tb_flag_cond_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// Condition-flag register and branch resolver: stores ALU NZVC flags, resolves B.cond/CBZ/CBNZ
// one cycle after the request and keeps a saturating count of taken branches.
module flag_cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  input  logic        set_flags,
  input  logic        br_valid,
  input  logic [1:0]  br_type,
  input  logic [3:0]  br_cond,
  output logic [3:0]  flags_q,
  output logic        br_done,
  output logic        br_taken,
  output logic        br_illegal,
  output logic [15:0] taken_count
);

  localparam logic [1:0] BrCond = 2'b00;
  localparam logic [1:0] BrCbz  = 2'b01;
  localparam logic [1:0] BrCbnz = 2'b10;
  localparam logic [1:0] BrRsvd = 2'b11;

  logic [3:0]  alu_flags;
  logic [3:0]  eff_flags;
  logic        n, z, v, c;
  logic        cond_met;
  logic        taken_d, illegal_d;
  logic        done_q, taken_q, illegal_q;
  logic [15:0] count_d, count_q;

  assign alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};

  always_comb begin
    // Forward live ALU flags when they are being written this same cycle
    eff_flags    = set_flags ? alu_flags : flags_q;
    {n, z, v, c} = eff_flags;
    cond_met     = 1'b0;
    unique case (br_cond)
      4'b0000: cond_met = z;
      4'b0001: cond_met = !z;
      4'b0010: cond_met = c;
      4'b0011: cond_met = !c;
      4'b0100: cond_met = n;
      4'b0101: cond_met = !n;
      4'b0110: cond_met = v;
      4'b0111: cond_met = !v;
      4'b1000: cond_met = c & !z;
      4'b1001: cond_met = !(c & !z);
      4'b1010: cond_met = (n == v);
      4'b1011: cond_met = (n != v);
      4'b1100: cond_met = !z & (n == v);
      4'b1101: cond_met = !(!z & (n == v));
      4'b1110: cond_met = 1'b1;
      4'b1111: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    if (br_valid) begin
      unique case (br_type)
        BrCond:  taken_d   = cond_met;
        BrCbz:   taken_d   = alu_zero;
        BrCbnz:  taken_d   = !alu_zero;
        BrRsvd:  illegal_d = 1'b1;
        default: taken_d   = 1'b0;
      endcase
    end
    count_d = count_q;
    if (taken_d && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      if (set_flags) begin
        flags_q <= alu_flags;
      end
      done_q    <= br_valid;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign br_done     = done_q;
  assign br_taken    = taken_q;
  assign br_illegal  = illegal_q;
  assign taken_count = count_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Randomized and directed bench for flag_cond_unit against a behavioural NZVC branch model.
module tb_flag_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        set_flags, br_valid;
  logic [1:0]  br_type;
  logic [3:0]  br_cond;
  logic [3:0]  flags_q;
  logic        br_done, br_taken, br_illegal;
  logic [15:0] taken_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic       m_done, m_taken, m_ill;
  int         m_count;

  always #5 clk = ~clk;

  flag_cond_unit dut (
    .clk          (clk),
    .reset        (reset),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry_out(alu_carry_out),
    .set_flags    (set_flags),
    .br_valid     (br_valid),
    .br_type      (br_type),
    .br_cond      (br_cond),
    .flags_q      (flags_q),
    .br_done      (br_done),
    .br_taken     (br_taken),
    .br_illegal   (br_illegal),
    .taken_count  (taken_count)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Conditions come in pairs: odd code is the negation of the even one, 111x always holds.
  function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
    bit nf, zf, vf, cf, base;
    nf = f[3]; zf = f[2]; vf = f[1]; cf = f[0];
    case (cond[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf && !zf;
      3'd5: base = (nf == vf);
      3'd6: base = !zf && (nf == vf);
      default: return 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic step(input string tag, input bit rst, input bit sf, input logic [3:0] alu,
                      input bit bv, input logic [1:0] bt, input logic [3:0] bc, input bit chk);
    logic [3:0] eff;
    reset = rst;
    set_flags = sf;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = alu;
    br_valid = bv;
    br_type = bt;
    br_cond = bc;
    if (rst) begin
      m_flags = 4'b0; m_done = 0; m_taken = 0; m_ill = 0; m_count = 0;
    end else begin
      eff = sf ? alu : m_flags;
      m_done = bv;
      m_ill = bv && (bt == 2'b11);
      m_taken = 0;
      if (bv) begin
        if (bt == 2'b00) m_taken = cond_holds(bc, eff);
        else if (bt == 2'b01) m_taken = alu[2];
        else if (bt == 2'b10) m_taken = !alu[2];
      end
      if (m_taken && m_count < 65535) m_count++;
      if (sf) m_flags = alu;
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check_eq({tag, ".flags"}, {12'b0, flags_q}, {12'b0, m_flags});
      check_eq({tag, ".done"}, {15'b0, br_done}, {15'b0, m_done});
      check_eq({tag, ".taken"}, {15'b0, br_taken}, {15'b0, m_taken});
      check_eq({tag, ".illegal"}, {15'b0, br_illegal}, {15'b0, m_ill});
      check_eq({tag, ".count"}, taken_count, m_count[15:0]);
    end
  endtask

  initial begin
    reset = 1; set_flags = 0; br_valid = 0; br_type = 0; br_cond = 0;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'b0;

    step("reset0", 1, 0, 4'h0, 0, 2'b00, 4'h0, 1);
    step("reset1", 1, 0, 4'h0, 0, 2'b00, 4'h0, 1);
    check_eq("reset_flags", {12'b0, flags_q}, 16'h0000);
    check_eq("reset_count", taken_count, 16'h0000);

    // First request after reset sees all-zero flags
    step("first_eq", 0, 0, 4'h0, 1, 2'b00, 4'b0000, 1);
    check_eq("first_eq_taken", {15'b0, br_taken}, 16'h0000);
    step("first_ne", 0, 0, 4'h0, 1, 2'b00, 4'b0001, 1);
    check_eq("first_ne_taken", {15'b0, br_taken}, 16'h0001);

    // Stored flags: N=0 Z=1 V=0 C=1, then EQ
    step("store", 0, 1, 4'b0101, 0, 2'b00, 4'h0, 1);
    check_eq("store_flags", {12'b0, flags_q}, 16'h0005);
    step("store_eq", 0, 0, 4'b0000, 1, 2'b00, 4'b0000, 1);
    check_eq("store_eq_done", {15'b0, br_done}, 16'h0001);
    check_eq("store_eq_taken", {15'b0, br_taken}, 16'h0001);

    // Forwarding from flags_q = 0000
    step("clr", 0, 1, 4'b0000, 0, 2'b00, 4'h0, 1);
    step("fwd_eq", 0, 1, 4'b0100, 1, 2'b00, 4'b0000, 1);
    check_eq("fwd_taken", {15'b0, br_taken}, 16'h0001);
    check_eq("fwd_flags", {12'b0, flags_q}, 16'h0004);

    // Signed compares, N=1 V=0
    step("nv10", 0, 1, 4'b1000, 0, 2'b00, 4'h0, 1);
    step("ge", 0, 0, 4'h0, 1, 2'b00, 4'b1010, 1);
    check_eq("ge_taken", {15'b0, br_taken}, 16'h0000);
    step("lt", 0, 0, 4'h0, 1, 2'b00, 4'b1011, 1);
    check_eq("lt_taken", {15'b0, br_taken}, 16'h0001);
    step("le", 0, 0, 4'h0, 1, 2'b00, 4'b1101, 1);
    check_eq("le_taken", {15'b0, br_taken}, 16'h0001);
    step("nv11", 0, 1, 4'b1010, 0, 2'b00, 4'h0, 1);
    step("gt", 0, 0, 4'h0, 1, 2'b00, 4'b1100, 1);
    check_eq("gt_taken", {15'b0, br_taken}, 16'h0001);

    // CBZ, CBNZ, reserved back to back; alu_zero=1 without set_flags
    step("cbz", 0, 0, 4'b0100, 1, 2'b01, 4'h0, 1);
    check_eq("cbz_taken", {15'b0, br_taken}, 16'h0001);
    step("cbnz", 0, 0, 4'b0100, 1, 2'b10, 4'h0, 1);
    check_eq("cbnz_taken", {15'b0, br_taken}, 16'h0000);
    step("rsvd", 0, 0, 4'b0100, 1, 2'b11, 4'h0, 1);
    check_eq("rsvd_illegal", {15'b0, br_illegal}, 16'h0001);
    check_eq("rsvd_flags", {12'b0, flags_q}, 16'h000A);
    step("idle", 0, 1, 4'b0011, 0, 2'b11, 4'hF, 1);
    check_eq("sf_only_done", {15'b0, br_done}, 16'h0000);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1), 4'($urandom),
           ($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 1);
    end

    // Reset mid-operation with request and set_flags
    step("pre_rst", 0, 1, 4'b1111, 1, 2'b00, 4'b1110, 1);
    step("mid_rst", 1, 1, 4'b1111, 1, 2'b00, 4'b1110, 1);
    check_eq("mid_rst_done", {15'b0, br_done}, 16'h0000);
    check_eq("mid_rst_flags", {12'b0, flags_q}, 16'h0000);
    check_eq("mid_rst_count", taken_count, 16'h0000);
    step("post_rst", 0, 0, 4'h0, 0, 2'b00, 4'h0, 1);

    // Saturation: bring count to FFFE then three always-taken requests
    for (int i = 0; i < 65534; i++) begin
      step("fill", 0, 0, 4'h0, 1, 2'b00, 4'b1110, 0);
    end
    check_eq("fill_count", taken_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step("sat", 0, 0, 4'h0, 1, 2'b00, 4'b1110, 1);
      check_eq("sat_count", taken_count, 16'hFFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
